lfsr_checker: RTL and testbench
===============================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 4, consecutive chained words needed to declare lock (legal 2..15).
REQ-002 SHALL have parameter LOSS_COUNT, default 3, consecutive mismatching words needed to declare loss of lock (legal 1..15).
REQ-003 SHALL have port clock  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port din  input  64  received pattern word from the upstream 64-bit LFSR generator.
REQ-006 SHALL have port din_valid  input  1  din is sampled this cycle; no backpressure.
REQ-007 SHALL have port clear_counts  input  1  synchronous clear of all counters.
REQ-008 SHALL have port locked  output  1  checker is in LOCKED state.
REQ-009 SHALL have port lock_lost  output  1  one-cycle pulse on LOCKED->HUNT transition.
REQ-010 SHALL have port word_count  output  32  valid words checked while LOCKED.
REQ-011 SHALL have port err_word_count  output  32  mismatching words while LOCKED.
REQ-012 SHALL have port err_bit_count  output  32  total mismatching bits while LOCKED.

Function
REQ-013 SHALL define NEXT(x) = {x[62]^x[61], x[61]^x[60], x[60]^x[59], x[59]^x[58], x[58:0], x[63]}, except NEXT(64'h9C69832196724182) = 64'hFFFF_FFFF_FFFF_FFFF (generator wrap).
REQ-014 SHALL hold a 64-bit expected register, a 4-bit match counter and a 4-bit miss counter; none change on cycles with din_valid=0.
REQ-015 SHALL implement two states, HUNT and LOCKED; locked=1 exactly in LOCKED.
REQ-016 HUNT, din_valid=1: expected <= NEXT(din); if match counter >0 and din==expected, match counter increments, else match counter <= 1.
REQ-017 HUNT: when the incremented match counter equals LOCK_COUNT, SHALL enter LOCKED on that edge (locked visible next cycle), clear miss counter.
REQ-018 LOCKED, din_valid=1: expected <= NEXT(expected) (flywheel, never reseeded from din); word_count increments.
REQ-019 LOCKED match (din==expected): miss counter <= 0.
REQ-020 LOCKED mismatch: err_word_count += 1, err_bit_count += popcount(din ^ expected), miss counter increments.
REQ-021 LOCKED: when the incremented miss counter equals LOSS_COUNT, SHALL enter HUNT, clear match counter, pulse lock_lost for exactly one cycle; that word is still counted.
REQ-022 All counters SHALL saturate at 32'hFFFF_FFFF; err_bit_count addition saturates, never wraps.
REQ-023 clear_counts=1 SHALL zero the three counters on that edge, overriding any same-cycle increment; state, expected and lock counters unaffected.
REQ-024 All outputs SHALL be registered; counter and status updates visible one cycle after the sampled word.

Reset
REQ-025 reset=1 SHALL, on the next rising edge, set state HUNT, expected 64'hFFFF_FFFF_FFFF_FFFF, match/miss counters 0, locked 0, lock_lost 0, all counters 0.
REQ-026 reset SHALL take priority over din_valid and clear_counts, including mid-lock; lock must be re-acquired afterwards.

Verification
REQ-027 Reset, then valid words FFFF_FFFF_FFFF_FFFF, 0FFF_FFFF_FFFF_FFFF, then its NEXT and the next NEXT -> locked=1 one cycle after the 4th word; all counters 0.
REQ-028 Locked, stream continues through 9C69832196724182 followed by FFFF_FFFF_FFFF_FFFF -> no errors; word_count equals words sent after lock.
REQ-029 Locked, one word with bits 0 and 63 flipped, then correct words -> err_word_count=1, err_bit_count=2, locked stays 1, flywheel stays aligned.
REQ-030 Locked, 3 consecutive corrupted words -> lock_lost pulses one cycle after the 3rd, locked=0, err_word_count=3; a 2-corrupt-then-good run keeps lock.
REQ-031 din_valid gaps of 0..5 idle cycles between words -> identical results to gapless stream; clear_counts asserted same cycle as a mismatch -> counters read 0 next cycle.
REQ-032 reset asserted for one cycle while locked -> next cycle locked=0, all counters 0, expected FFFF_FFFF_FFFF_FFFF.

Source files
------------

// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if: pattern word stream into the checker and its status/counter outputs.
// Latency: none (wires only).
// Backpressure: none; the source may present a word every cycle.
interface lfsr_checker_if;
  logic [63:0] din;
  logic        din_valid;
  logic        clear_counts;
  logic        locked;
  logic        lock_lost;
  logic [31:0] word_count;
  logic [31:0] err_word_count;
  logic [31:0] err_bit_count;

  // Stream source / register reader side
  modport master (
    output din, din_valid, clear_counts,
    input  locked, lock_lost, word_count, err_word_count, err_bit_count
  );

  // Checker side
  modport slave (
    input  din, din_valid, clear_counts,
    output locked, lock_lost, word_count, err_word_count, err_bit_count
  );
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker: locks onto a 64-bit LFSR pattern stream, then counts words, bad words and bad bits.
// Latency: state and counters update one cycle after each sampled word.
// Backpressure: none; every din_valid word is consumed.
module lfsr_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3
) (
  input logic           clock,
  input logic           reset,
  lfsr_checker_if.slave bus
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [63:0] WRAP_WORD = 64'h9C69_8321_9672_4182;
  localparam logic [63:0] SEED_WORD = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [3:0]  LOCK_CNT  = 4'(LOCK_COUNT);
  localparam logic [3:0]  LOSS_CNT  = 4'(LOSS_COUNT);
  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

  // Generator step; the upstream generator restarts from all-ones after WRAP_WORD.
  function automatic logic [63:0] next_word(input logic [63:0] x);
    logic [63:0] y;
    if (x == WRAP_WORD) begin
      y = SEED_WORD;
    end else begin
      y = {x[62] ^ x[61], x[61] ^ x[60], x[60] ^ x[59], x[59] ^ x[58], x[58:0], x[63]};
    end
    return y;
  endfunction

  // Registered state
  state_t      r_state;
  logic [63:0] r_expected;
  logic [3:0]  r_match_cnt;
  logic [3:0]  r_miss_cnt;
  logic        r_lock_lost;
  logic [31:0] r_word_cnt;
  logic [31:0] r_err_word_cnt;
  logic [31:0] r_err_bit_cnt;

  // Next-state values
  state_t      w_state_nxt;
  logic [63:0] w_expected_nxt;
  logic [3:0]  w_match_cnt_nxt;
  logic [3:0]  w_miss_cnt_nxt;
  logic        w_lock_lost_nxt;
  logic [31:0] w_word_cnt_nxt;
  logic [31:0] w_err_word_cnt_nxt;
  logic [31:0] w_err_bit_cnt_nxt;

  // Compare path shared by both states
  logic [63:0] w_diff;
  logic        w_match;
  logic [6:0]  w_popcnt;
  logic [32:0] w_bit_sum;
  logic [3:0]  w_match_inc;
  logic [3:0]  w_miss_inc;

  assign w_diff      = bus.din ^ r_expected;
  assign w_match     = (w_diff == 64'd0);
  assign w_popcnt    = 7'($countones(w_diff));
  assign w_bit_sum   = {1'b0, r_err_bit_cnt} + {26'd0, w_popcnt};
  assign w_match_inc = r_match_cnt + 4'd1;
  assign w_miss_inc  = r_miss_cnt + 4'd1;

  // Next-state and counter update: hunt reseeds from din, locked flywheels on expected
  always_comb begin
    w_state_nxt        = r_state;
    w_expected_nxt     = r_expected;
    w_match_cnt_nxt    = r_match_cnt;
    w_miss_cnt_nxt     = r_miss_cnt;
    w_lock_lost_nxt    = 1'b0;
    w_word_cnt_nxt     = r_word_cnt;
    w_err_word_cnt_nxt = r_err_word_cnt;
    w_err_bit_cnt_nxt  = r_err_bit_cnt;

    if (bus.din_valid) begin
      unique case (r_state)
        HUNT: begin
          w_expected_nxt = next_word(bus.din);
          // A word only extends the chain if a chain is already running
          if ((r_match_cnt != 4'd0) && w_match) begin
            w_match_cnt_nxt = w_match_inc;
          end else begin
            w_match_cnt_nxt = 4'd1;
          end
          if (w_match_cnt_nxt == LOCK_CNT) begin
            w_state_nxt    = LOCKED;
            w_miss_cnt_nxt = 4'd0;
          end
        end
        LOCKED: begin
          w_expected_nxt = next_word(r_expected);
          if (r_word_cnt != CNT_MAX) begin
            w_word_cnt_nxt = r_word_cnt + 32'd1;
          end
          if (w_match) begin
            w_miss_cnt_nxt = 4'd0;
          end else begin
            if (r_err_word_cnt != CNT_MAX) begin
              w_err_word_cnt_nxt = r_err_word_cnt + 32'd1;
            end
            w_err_bit_cnt_nxt = w_bit_sum[32] ? CNT_MAX : w_bit_sum[31:0];
            w_miss_cnt_nxt    = w_miss_inc;
            // The losing word is still counted above
            if (w_miss_inc == LOSS_CNT) begin
              w_state_nxt     = HUNT;
              w_match_cnt_nxt = 4'd0;
              w_lock_lost_nxt = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = HUNT;
        end
      endcase
    end

    // Counter clear wins over any increment in the same cycle
    if (bus.clear_counts) begin
      w_word_cnt_nxt     = 32'd0;
      w_err_word_cnt_nxt = 32'd0;
      w_err_bit_cnt_nxt  = 32'd0;
    end
  end

  // State register with synchronous reset taking priority over everything
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= HUNT;
      r_expected     <= SEED_WORD;
      r_match_cnt    <= 4'd0;
      r_miss_cnt     <= 4'd0;
      r_lock_lost    <= 1'b0;
      r_word_cnt     <= 32'd0;
      r_err_word_cnt <= 32'd0;
      r_err_bit_cnt  <= 32'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_expected     <= w_expected_nxt;
      r_match_cnt    <= w_match_cnt_nxt;
      r_miss_cnt     <= w_miss_cnt_nxt;
      r_lock_lost    <= w_lock_lost_nxt;
      r_word_cnt     <= w_word_cnt_nxt;
      r_err_word_cnt <= w_err_word_cnt_nxt;
      r_err_bit_cnt  <= w_err_bit_cnt_nxt;
    end
  end

  // LOCKED encodes as 1, so locked is the state flop itself
  assign bus.locked         = (r_state == LOCKED);
  assign bus.lock_lost      = r_lock_lost;
  assign bus.word_count     = r_word_cnt;
  assign bus.err_word_count = r_err_word_cnt;
  assign bus.err_bit_count  = r_err_bit_cnt;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed pattern streams with hand-computed expected status/counters.
// Latency: each checked word is compared one cycle after it is sampled.
// Backpressure: none; the driver issues words, the monitor checks independently.
module tb_lfsr_checker;

  typedef struct packed {
    int          id;
    logic        locked;
    logic        lock_lost;
    logic [31:0] wc;
    logic [31:0] ewc;
    logic [31:0] ebc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  lfsr_checker_if bus();

  lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  exp_t exp_q[$];
  exp_t mon_e;
  logic issue   = 1'b0;
  logic issue_q = 1'b0;
  int   total   = 0;
  int   bad     = 0;
  int   nchk    = 0;
  logic [63:0] g;

  // Stimulus generator: rotate left by one, top nibble from the tap XOR
  function automatic logic [63:0] gen_next(input logic [63:0] x);
    if (x == 64'h9C69_8321_9672_4182) return 64'hFFFF_FFFF_FFFF_FFFF;
    return {x[62:59] ^ x[61:58], x[58:0], x[63]};
  endfunction

  // Inverse generator step, used to build a stream that runs into the wrap word
  function automatic logic [63:0] gen_prev(input logic [63:0] y);
    logic [63:0] x;
    x[58:0] = y[59:1];
    x[63]   = y[0];
    x[59]   = y[60] ^ x[58];
    x[60]   = y[61] ^ x[59];
    x[61]   = y[62] ^ x[60];
    x[62]   = y[63] ^ x[61];
    return x;
  endfunction

  function automatic exp_t E(input logic lk, input logic ll, input int wc, input int ewc, input int ebc);
    exp_t e;
    e.id        = 0;
    e.locked    = lk;
    e.lock_lost = ll;
    e.wc        = wc;
    e.ewc       = ewc;
    e.ebc       = ebc;
    return e;
  endfunction

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s (check %0d): got %0h required %0h", name, id, act, req);
    end
  endtask

  // Scoreboard monitor: a check issued on a cycle is compared one cycle later
  always @(posedge clock) issue_q <= issue;

  always @(negedge clock) begin
    if (issue_q) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow: got 0 entries required 1");
      end else begin
        mon_e = exp_q.pop_front();
        check("locked",         mon_e.id, {31'd0, bus.locked},    {31'd0, mon_e.locked});
        check("lock_lost",      mon_e.id, {31'd0, bus.lock_lost}, {31'd0, mon_e.lock_lost});
        check("word_count",     mon_e.id, bus.word_count,         mon_e.wc);
        check("err_word_count", mon_e.id, bus.err_word_count,     mon_e.ewc);
        check("err_bit_count",  mon_e.id, bus.err_bit_count,      mon_e.ebc);
      end
    end
  end

  task automatic step(input logic rst, input logic vld, input logic [63:0] d, input logic clr,
                      input logic chk, input exp_t e);
    exp_t t;
    @(negedge clock);
    reset            = rst;
    bus.din_valid    = vld;
    bus.din          = d;
    bus.clear_counts = clr;
    issue            = chk;
    if (chk) begin
      t    = e;
      t.id = nchk;
      nchk++;
      exp_q.push_back(t);
    end
    @(posedge clock);
  endtask

  task automatic word(input logic [63:0] d, input exp_t e);
    step(1'b0, 1'b1, d, 1'b0, 1'b1, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, E(0, 0, 0, 0, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.din          = 64'd0;
    bus.din_valid    = 1'b0;
    bus.clear_counts = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 64'd0, 1'b0, 1'b0, E(0, 0, 0, 0, 0));
    step(1'b1, 1'b1, 64'd0, 1'b1, 1'b1, E(0, 0, 0, 0, 0));

    // Acquire lock from the seed word
    word(64'hFFFF_FFFF_FFFF_FFFF, E(0, 0, 0, 0, 0));
    word(64'h0FFF_FFFF_FFFF_FFFF, E(0, 0, 0, 0, 0));
    g = gen_next(64'h0FFF_FFFF_FFFF_FFFF);
    word(g, E(0, 0, 0, 0, 0)); g = gen_next(g);
    word(g, E(1, 0, 0, 0, 0)); g = gen_next(g);

    // Clean locked words
    for (int k = 1; k <= 3; k++) begin
      word(g, E(1, 0, k, 0, 0)); g = gen_next(g);
    end

    // Bits 0 and 63 flipped, then clean words keep alignment
    word(g ^ 64'h8000_0000_0000_0001, E(1, 0, 4, 1, 2)); g = gen_next(g);
    word(g, E(1, 0, 5, 1, 2)); g = gen_next(g);
    word(g, E(1, 0, 6, 1, 2)); g = gen_next(g);

    // Two bad then good keeps lock
    word(g ^ 64'h20, E(1, 0, 7, 2, 3)); g = gen_next(g);
    word(g ^ 64'hE,  E(1, 0, 8, 3, 6)); g = gen_next(g);
    word(g,          E(1, 0, 9, 3, 6)); g = gen_next(g);

    // Clear on an idle cycle, then three bad words lose lock
    step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, E(1, 0, 0, 0, 0));
    word(g ^ (64'd1 << 10), E(1, 0, 1, 1, 1)); g = gen_next(g);
    word(g ^ (64'd1 << 20), E(1, 0, 2, 2, 2)); g = gen_next(g);
    word(g ^ (64'd1 << 30), E(0, 1, 3, 3, 3)); g = gen_next(g);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, E(0, 0, 3, 3, 3));
    word(g, E(0, 0, 3, 3, 3)); g = gen_next(g);

    // Fresh reset, then a gapped stream that runs through the wrap word
    step(1'b1, 1'b0, 64'd0, 1'b0, 1'b1, E(0, 0, 0, 0, 0));
    g = 64'h9C69_8321_9672_4182;
    for (int i = 0; i < 6; i++) g = gen_prev(g);
    for (int i = 0; i < 10; i++) begin
      idle(i % 6);
      if (i < 3)       word(g, E(0, 0, 0, 0, 0));
      else if (i == 3) word(g, E(1, 0, 0, 0, 0));
      else             word(g, E(1, 0, i - 3, 0, 0));
      g = gen_next(g);
    end

    // Clear in the same cycle as a mismatch
    step(1'b0, 1'b1, g ^ 64'h80, 1'b1, 1'b1, E(1, 0, 0, 0, 0)); g = gen_next(g);
    word(g, E(1, 0, 1, 0, 0)); g = gen_next(g);
    idle(2);
    word(g, E(1, 0, 2, 0, 0)); g = gen_next(g);

    // One-cycle reset while locked, with a valid word present
    step(1'b1, 1'b1, g, 1'b0, 1'b1, E(0, 0, 0, 0, 0)); g = gen_next(g);
    word(g, E(0, 0, 0, 0, 0)); g = gen_next(g);
    word(g, E(0, 0, 0, 0, 0)); g = gen_next(g);
    word(g, E(0, 0, 0, 0, 0)); g = gen_next(g);
    word(g, E(1, 0, 0, 0, 0)); g = gen_next(g);
    word(g, E(1, 0, 1, 0, 0)); g = gen_next(g);

    idle(3);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
